// File: rtl/reg_file_pkg.sv
// Shared register-file constants and the 5-bit register-index type.
// Used by reg_file and by the RegDst mux that produces WriteReg.
package reg_file_pkg;

    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned COUNT_W   = 8;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_SP   = 5'd29;
    localparam reg_idx_t REG_RA   = 5'd31;

endpackage : reg_file_pkg

// File: rtl/reg_bypass.sv
// Write-first forwarding compare for one register-file read port.
// When BYPASS_EN is set and this port reads the register being committed on
// the same edge, the incoming write data is selected instead of the stored
// contents.
//   rd_addr   : read port register index
//   wr_en     : a write to a non-zero register commits this edge
//   wr_addr   : destination register index
//   wr_data   : data being written
//   rf_data   : stored contents of rd_addr
//   rd_data_c : combinational next value for the registered read data
module reg_bypass
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter bit          BYPASS_EN = 1'b0
) (
    input  reg_idx_t          rd_addr,
    input  logic              wr_en,
    input  reg_idx_t          wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] rd_data_c
);

    logic hit_c;

    assign hit_c     = BYPASS_EN && wr_en && (rd_addr == wr_addr);
    assign rd_data_c = hit_c ? wr_data : rf_data;

endmodule : reg_bypass

// File: rtl/reg_file.sv
// 32-entry register file for the multi-cycle datapath, with registered
// (A/B latch) read ports and a modulo-256 count of committed writes.
// Register 0 is hard-wired to zero; registers 29 and 31 reset to SP_INIT and
// RA_INIT. Define REGFILE_BYPASS_EN for write-first reads on a same-edge
// write; otherwise reads return the old contents (read-first).
//   clk        : clock, rising edge
//   reset      : asynchronous reset, active low
//   RegWrite   : write enable
//   WriteReg   : destination register index
//   WriteData  : write data
//   ReadReg1/2 : source register indices
//   ReadData1/2: registered read data
//   WriteCount : committed-write counter
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned       DATA_W  = 32,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(32'd227),
    parameter logic [DATA_W-1:0] RA_INIT = DATA_W'(32'd0)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               RegWrite,
    input  reg_idx_t           WriteReg,
    input  logic [DATA_W-1:0]  WriteData,
    input  reg_idx_t           ReadReg1,
    input  reg_idx_t           ReadReg2,
    output logic [DATA_W-1:0]  ReadData1,
    output logic [DATA_W-1:0]  ReadData2,
    output logic [COUNT_W-1:0] WriteCount
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_commit_c;
    logic [DATA_W-1:0] rf_rd1_c;
    logic [DATA_W-1:0] rf_rd2_c;
    logic [DATA_W-1:0] rd1_c;
    logic [DATA_W-1:0] rd2_c;

    // Writes to register 0 are dropped and do not count.
    assign wr_commit_c = RegWrite && (WriteReg != REG_ZERO);

    assign rf_rd1_c = regs[ReadReg1];
    assign rf_rd2_c = regs[ReadReg2];

    reg_bypass #(
        .DATA_W    (DATA_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_bypass1 (
        .rd_addr   (ReadReg1),
        .wr_en     (wr_commit_c),
        .wr_addr   (WriteReg),
        .wr_data   (WriteData),
        .rf_data   (rf_rd1_c),
        .rd_data_c (rd1_c)
    );

    reg_bypass #(
        .DATA_W    (DATA_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_bypass2 (
        .rd_addr   (ReadReg2),
        .wr_en     (wr_commit_c),
        .wr_addr   (WriteReg),
        .wr_data   (WriteData),
        .rf_data   (rf_rd2_c),
        .rd_data_c (rd2_c)
    );

    // Register array; entry 0 is never written so it stays zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (REG_IDX_W'(i) == REG_SP) begin
                    regs[i] <= SP_INIT;
                end else if (REG_IDX_W'(i) == REG_RA) begin
                    regs[i] <= RA_INIT;
                end else begin
                    regs[i] <= '0;
                end
            end
        end else if (wr_commit_c) begin
            regs[WriteReg] <= WriteData;
        end
    end

    // Registered read ports and write counter (wraps silently).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ReadData1  <= '0;
            ReadData2  <= '0;
            WriteCount <= '0;
        end else begin
            ReadData1 <= rd1_c;
            ReadData2 <= rd2_c;
            if (wr_commit_c) begin
                WriteCount <= WriteCount + COUNT_W'(1);
            end
        end
    end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (default parameters).
module tb_reg_file;
    import reg_file_pkg::*;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    reg_idx_t    WriteReg;
    logic [31:0] WriteData;
    reg_idx_t    ReadReg1;
    reg_idx_t    ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [7:0]  WriteCount;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [31:0] model [32];
    logic [31:0] same_edge_exp;

    reg_file dut (
        .clk        (clk),
        .reset      (reset),
        .RegWrite   (RegWrite),
        .WriteReg   (WriteReg),
        .WriteData  (WriteData),
        .ReadReg1   (ReadReg1),
        .ReadReg2   (ReadReg2),
        .ReadData1  (ReadData1),
        .ReadData2  (ReadData2),
        .WriteCount (WriteCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full cycle: rising edge, then settle at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        RegWrite  = 1'b0;
        WriteReg  = 5'd0;
        WriteData = 32'd0;
        ReadReg1  = 5'd0;
        ReadReg2  = 5'd0;

        // Reset held across edges: outputs stay cleared.
        reset = 1'b0;
        #2;
        check("rst_rd1", ReadData1, 32'd0);
        check("rst_rd2", ReadData2, 32'd0);
        check("rst_wc", {24'd0, WriteCount}, 32'd0);
        ReadReg1 = 5'd29;
        ReadReg2 = 5'd31;
        RegWrite = 1'b1;
        WriteReg = 5'd3;
        WriteData = 32'hAAAA5555;
        tick();
        tick();
        check("rst_hold_rd1", ReadData1, 32'd0);
        check("rst_hold_wc", {24'd0, WriteCount}, 32'd0);
        RegWrite = 1'b0;

        // Release; first edge reads SP and RA reset values.
        reset = 1'b1;
        tick();
        check("sp_init", ReadData1, 32'd227);
        check("ra_init", ReadData2, 32'd0);
        check("wc_after_rst", {24'd0, WriteCount}, 32'd0);
        ReadReg1 = 5'd3;
        tick();
        check("reset_write_dropped", ReadData1, 32'd0);

        // Write reg 5, then read it.
        RegWrite  = 1'b1;
        WriteReg  = 5'd5;
        WriteData = 32'hDEADBEEF;
        tick();
        RegWrite = 1'b0;
        ReadReg1 = 5'd5;
        tick();
        check("rd_r5", ReadData1, 32'hDEADBEEF);
        check("wc_one", {24'd0, WriteCount}, 32'd1);

        // Write to reg 0 is discarded and not counted.
        RegWrite  = 1'b1;
        WriteReg  = 5'd0;
        WriteData = 32'hFFFFFFFF;
        tick();
        RegWrite = 1'b0;
        ReadReg1 = 5'd0;
        ReadReg2 = 5'd0;
        tick();
        check("r0_port1", ReadData1, 32'd0);
        check("r0_port2", ReadData2, 32'd0);
        check("r0_wc", {24'd0, WriteCount}, 32'd1);

        // Same-edge write/read of reg 8.
`ifdef REGFILE_BYPASS_EN
        same_edge_exp = 32'h12345678;
`else
        same_edge_exp = 32'd0;
`endif
        RegWrite  = 1'b1;
        WriteReg  = 5'd8;
        WriteData = 32'h12345678;
        ReadReg2  = 5'd8;
        tick();
        check("same_edge_rd2", ReadData2, same_edge_exp);
        check("same_edge_wc", {24'd0, WriteCount}, 32'd2);

        // RegWrite low: nothing changes, both ports agree on the same index.
        RegWrite  = 1'b0;
        WriteData = 32'h0BADF00D;
        ReadReg1  = 5'd8;
        ReadReg2  = 5'd8;
        tick();
        check("r8_port1", ReadData1, 32'h12345678);
        check("r8_port2", ReadData2, 32'h12345678);
        check("idle_wc", {24'd0, WriteCount}, 32'd2);

        // Reset asserted mid-cycle during a write to reg 29.
        RegWrite  = 1'b1;
        WriteReg  = 5'd29;
        WriteData = 32'h55555555;
        #2;
        reset = 1'b0;
        #1;
        check("async_rd1", ReadData1, 32'd0);
        check("async_wc", {24'd0, WriteCount}, 32'd0);
        @(negedge clk);
        RegWrite = 1'b0;
        reset    = 1'b1;
        ReadReg1 = 5'd29;
        ReadReg2 = 5'd8;
        tick();
        check("sp_kept", ReadData1, 32'd227);
        check("r8_cleared", ReadData2, 32'd0);
        check("wc_cleared", {24'd0, WriteCount}, 32'd0);

        // 256 non-zero writes wrap the counter to 0, the next gives 1.
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        model[29] = 32'd227;
        RegWrite = 1'b1;
        for (int i = 0; i < 256; i++) begin
            WriteReg  = 5'((i % 31) + 1);
            WriteData = 32'(i + 1) * 32'h01010101;
            model[(i % 31) + 1] = WriteData;
            tick();
        end
        RegWrite = 1'b0;
        check("wc_wrap", {24'd0, WriteCount}, 32'd0);
        RegWrite  = 1'b1;
        WriteReg  = 5'd1;
        WriteData = 32'hCAFEF00D;
        model[1]  = 32'hCAFEF00D;
        tick();
        RegWrite = 1'b0;
        check("wc_257", {24'd0, WriteCount}, 32'd1);

        // Read back every register pair against the model.
        for (int r = 0; r < 32; r += 2) begin
            ReadReg1 = 5'(r);
            ReadReg2 = 5'(r + 1);
            tick();
            check($sformatf("readback_r%0d", r), ReadData1, model[r]);
            check($sformatf("readback_r%0d", r + 1), ReadData2, model[r + 1]);
        end
        check("wc_final", {24'd0, WriteCount}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reg_file

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter SP_INIT, default 32'd227, reset value of register 29 (stack pointer).
REQ-003 SHALL have parameter RA_INIT, default 32'd0, reset value of register 31 (return address).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 RegWrite  input  1  write enable from control FSM.
REQ-007 WriteReg  input  5  destination register number, driven by the RegDst mux.
REQ-008 WriteData  input  DATA_W  data to write, driven by the MemToReg mux.
REQ-009 ReadReg1  input  5  first source register number, from IR[25:21].
REQ-010 ReadReg2  input  5  second source register number, from IR[20:16].
REQ-011 ReadData1  output  DATA_W  registered contents of ReadReg1.
REQ-012 ReadData2  output  DATA_W  registered contents of ReadReg2.
REQ-013 WriteCount  output  8  count of committed writes, wraps modulo 256.

Function
REQ-014 SHALL hold 32 registers of DATA_W bits, indexed 0..31.
REQ-015 Register 0 SHALL always read 0; writes to 0 SHALL be discarded and SHALL NOT increment WriteCount.
REQ-016 On a rising edge with RegWrite=1 and WriteReg!=0, register[WriteReg] SHALL take WriteData and WriteCount SHALL increment by 1.
REQ-017 On a rising edge, ReadData1/ReadData2 SHALL load register[ReadReg1]/register[ReadReg2], giving 1-cycle read latency; this matches the A/B latch stage of the multi-cycle datapath.
REQ-018 With REGFILE_BYPASS_EN undefined, a read of the register written on the same edge SHALL return the old value.
REQ-019 WriteCount SHALL wrap from 255 to 0 with no flag.
REQ-020 With RegWrite=0, no register and no WriteCount bit SHALL change.
REQ-021 Both read ports SHALL be independent; ReadReg1==ReadReg2 SHALL return the same value on both ports.

Reset
REQ-022 While reset=0, registers 1..28 and 30 SHALL be 0, register 29 SHALL be SP_INIT, register 31 SHALL be RA_INIT, ReadData1/2 SHALL be 0, and WriteCount SHALL be 0, regardless of clk.
REQ-023 Reset asserted during a write cycle SHALL discard the write.
REQ-024 The first rising edge after reset deasserts SHALL perform normal reads and writes.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN: when defined, a read port whose address equals a non-zero WriteReg being written on the same edge SHALL load WriteData (write-first); when undefined, that port SHALL load the old contents (read-first, REQ-018).

Structure
REQ-026 A shared package SHALL hold NUM_REGS=32, REG_ZERO=0, REG_SP=29 and REG_RA=31 constants, plus the 5-bit register-index typedef used by this block and the RegDst mux.
REQ-027 The write-first forwarding compare SHALL be one sub-module, reg_bypass, instantiated once per read port; no other sub-modules.

Verification
REQ-028 Reset pulse low, then ReadReg1=29, ReadReg2=31 -> next edge ReadData1=227, ReadData2=0, WriteCount=0.
REQ-029 Write 32'hDEADBEEF to reg 5, next cycle ReadReg1=5 -> ReadData1=32'hDEADBEEF, WriteCount=1.
REQ-030 Write 32'hFFFFFFFF to reg 0, then read reg 0 -> ReadData=0, WriteCount unchanged.
REQ-031 Write 32'h12345678 to reg 8 with ReadReg2=8 on the same edge -> ReadData2=old value (0) without REGFILE_BYPASS_EN; 32'h12345678 with it.
REQ-032 Perform 256 non-zero writes -> WriteCount=0; the 257th write -> WriteCount=1.
REQ-033 Assert reset mid-cycle while RegWrite=1 to reg 29 -> reg 29 remains 227 and WriteCount=0 after release.
